// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - framed byte-stream loader writing 32-bit words into instruction memory (option: INST_LOADER_CHECKSUM_EN)
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef INST_MEM_SIZE
`define INST_MEM_SIZE 1024
`endif

module inst_mem_loader #(
   parameter int MEM_DEPTH = `INST_MEM_SIZE
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            byte_valid,
   input  logic [7:0]                      byte_data,
   output logic                            byte_ready,
   output logic                            mem_we,
   output logic [`PC_WIDTH-1:0]            mem_addr,
   output logic [`INSTRUCTION_WIDTH-1:0]   mem_wdata,
   output logic                            core_hold,
   output logic                            done,
   output logic                            error
);

   localparam int PCW = `PC_WIDTH;
   localparam int IW  = `INSTRUCTION_WIDTH;
   localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CNT_HI = 3'd1,
      CNT_LO = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
`ifdef INST_LOADER_CHECKSUM_EN
      , CSUM = 3'd6
`endif
   } state_t;

`ifdef INST_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CSUM;
`else
   localparam state_t AFTER_DATA = DONE;
`endif

   state_t      state;
   state_t      next_state;
   logic [15:0] count;
   logic [15:0] word_addr;
   logic [1:0]  lane;
   logic [23:0] shift;
   logic [15:0] cnt_full;
   logic        fire;
   logic        start_ok;
   logic        last_byte;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   // count as it will be once the low byte currently on the bus is taken
   assign cnt_full  = {count[15:8], byte_data};
   // fourth byte of the final word of the frame
   assign last_byte = (lane == 2'd3) && (word_addr == count - 16'd1);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // next-state decode and state-derived outputs
   always_comb begin
      next_state = state;
      byte_ready = 1'b0;
      core_hold  = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      start_ok   = 1'b0;
      case (state)
         IDLE:  start_ok = start;
         DONE: begin
            done     = 1'b1;
            start_ok = start;
         end
         ERROR: begin
            error    = 1'b1;
            start_ok = start;
         end
         CNT_HI: begin
            byte_ready = 1'b1;
            core_hold  = 1'b1;
            if (byte_valid) next_state = CNT_LO;
         end
         CNT_LO: begin
            byte_ready = 1'b1;
            core_hold  = 1'b1;
            if (byte_valid) begin
               if ({16'd0, cnt_full} > DEPTH_W) next_state = ERROR;
               else if (cnt_full == 16'd0)      next_state = AFTER_DATA;
               else                             next_state = DATA;
            end
         end
         DATA: begin
            byte_ready = 1'b1;
            core_hold  = 1'b1;
            if (byte_valid && last_byte) next_state = AFTER_DATA;
         end
`ifdef INST_LOADER_CHECKSUM_EN
         CSUM: begin
            byte_ready = 1'b1;
            core_hold  = 1'b1;
            if (byte_valid) next_state = (byte_data == csum) ? DONE : ERROR;
         end
`endif
         default: next_state = IDLE;
      endcase
      if (start_ok) next_state = CNT_HI;
      fire = byte_valid && byte_ready;
   end

   // count capture, word assembly, write strobe and address tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count     <= 16'd0;
         word_addr <= 16'd0;
         lane      <= 2'd0;
         shift     <= 24'd0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
         csum      <= 8'd0;
`endif
      end else begin
         mem_we <= 1'b0;
         if (start_ok) begin
            lane      <= 2'd0;
            word_addr <= 16'd0;
            shift     <= 24'd0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
         end
         if (fire) begin
            case (state)
               CNT_HI: count[15:8] <= byte_data;
               CNT_LO: count[7:0]  <= byte_data;
               DATA: begin
`ifdef INST_LOADER_CHECKSUM_EN
                  csum <= csum ^ byte_data;
`endif
                  lane <= lane + 2'd1;
                  if (lane == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= PCW'(word_addr);
                     mem_wdata <= IW'({shift, byte_data});
                     word_addr <= word_addr + 16'd1;
                  end else begin
                     shift <= {shift[15:0], byte_data};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - scoreboard bench for inst_mem_loader
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module tb_inst_mem_loader;

   localparam int DEPTH = 16;

   logic                          clk = 1'b0;
   logic                          rst = 1'b0;
   logic                          start = 1'b0;
   logic                          byte_valid = 1'b0;
   logic [7:0]                    byte_data = 8'd0;
   logic                          byte_ready;
   logic                          mem_we;
   logic [`PC_WIDTH-1:0]          mem_addr;
   logic [`INSTRUCTION_WIDTH-1:0] mem_wdata;
   logic                          core_hold;
   logic                          done;
   logic                          error;

   int tests = 0;
   int fails = 0;

   logic [47:0] sb[$];
   logic [31:0] prog[DEPTH];

   inst_mem_loader #(.MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_hold(core_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write addr=%0h data=%08h (no write expected)", mem_addr, mem_wdata);
         end else begin
            logic [47:0] e;
            e = sb.pop_front();
            if (mem_addr !== `PC_WIDTH'(e[47:32]) || mem_wdata !== `INSTRUCTION_WIDTH'(e[31:0])) begin
               fails++;
               $display("FAIL write_value got addr=%0h data=%08h want addr=%0h data=%08h",
                        mem_addr, mem_wdata, e[47:32], e[31:0]);
            end
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // present a byte and return on the negedge after it was accepted
   task automatic send_byte(input logic [7:0] b, input bit throttle);
      int n;
      n = 0;
      if (throttle) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         tests++;
         fails++;
         $display("FAIL byte_timeout byte=%02h byte_ready=%b want 1", b, byte_ready);
      end
      @(negedge clk);
   endtask

   task automatic run_load(input int nw, input bit throttle, input bit bad_csum);
      logic [15:0] cnt;
      logic [7:0]  x;
      logic [7:0]  b;
      logic [31:0] w;
      cnt = 16'(nw);
      x   = 8'd0;
      pulse_start();
      tests++;
      if (core_hold !== 1'b1) begin
         fails++;
         $display("FAIL hold_after_start got %b want 1", core_hold);
      end
      send_byte(cnt[15:8], throttle);
      send_byte(cnt[7:0], throttle);
      for (int k = 0; k < nw; k++) begin
         w = prog[k];
         for (int j = 0; j < 4; j++) begin
            b = w[31-8*j -: 8];
            x = x ^ b;
            if (j == 3) sb.push_back({16'(k), w});
            send_byte(b, throttle);
            if (j == 3) begin
               tests++;
               if (mem_we !== 1'b1) begin
                  fails++;
                  $display("FAIL we_latency word=%0d mem_we=%b want 1", k, mem_we);
               end
            end
`ifndef INST_LOADER_CHECKSUM_EN
            if (k == nw - 1 && j == 3) begin
               tests++;
               if (done !== 1'b1 || core_hold !== 1'b0) begin
                  fails++;
                  $display("FAIL done_with_last_we done=%b hold=%b want 1 0", done, core_hold);
               end
            end else
`endif
            begin
               tests++;
               if (core_hold !== 1'b1) begin
                  fails++;
                  $display("FAIL hold_during_load word=%0d got %b want 1", k, core_hold);
               end
            end
         end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? (x ^ 8'h01) : x, throttle);
`endif
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL missing_writes pending=%0d want 0", sb.size());
         sb.delete();
      end
      tests++;
      if (done !== !bad_csum || error !== bad_csum || core_hold !== 1'b0) begin
         fails++;
         $display("FAIL load_status done=%b error=%b hold=%b want %b %b 0",
                  done, error, core_hold, !bad_csum, bad_csum);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      byte_valid = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || core_hold !== 1'b0 ||
          done !== 1'b0 || error !== 1'b0 || byte_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs we=%b addr=%0h data=%0h hold=%b done=%b err=%b rdy=%b want all 0",
                  mem_we, mem_addr, mem_wdata, core_hold, done, error, byte_ready);
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         tests++;
         if (byte_ready !== 1'b0 || core_hold !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_accept rdy=%b hold=%b want 0 0", byte_ready, core_hold);
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic test_two_word(input bit throttle);
      prog[0] = 32'h20010005;
      prog[1] = 32'h08000010;
      run_load(2, throttle, 1'b0);
   endtask

   task automatic test_overflow();
      pulse_start();
      send_byte(8'(((DEPTH + 1) >> 8) & 255), 1'b0);
      send_byte(8'((DEPTH + 1) & 255), 1'b0);
      tests++;
      if (error !== 1'b1 || byte_ready !== 1'b0 || core_hold !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL overflow_error err=%b rdy=%b hold=%b done=%b want 1 0 0 0",
                  error, byte_ready, core_hold, done);
      end
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      pulse_start();
      tests++;
      if (error !== 1'b0 || byte_ready !== 1'b1) begin
         fails++;
         $display("FAIL start_clears_error err=%b rdy=%b want 0 1", error, byte_ready);
      end
      // loader now sits in CNT_HI; run_load's start must be ignored there
      prog[0] = 32'hCAFEF00D;
      run_load(1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_word();
      prog[0] = 32'h11223344;
      prog[1] = 32'h55667788;
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      sb.push_back({16'd0, prog[0]});
      for (int j = 0; j < 4; j++) send_byte(prog[0][31-8*j -: 8], 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      rst = 1'b0;
      byte_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (mem_we !== 1'b0 || byte_ready !== 1'b0 || core_hold !== 1'b0 ||
          mem_addr !== '0 || mem_wdata !== '0) begin
         fails++;
         $display("FAIL reset_mid_word we=%b rdy=%b hold=%b addr=%0h data=%0h want all 0",
                  mem_we, byte_ready, core_hold, mem_addr, mem_wdata);
      end
      rst = 1'b1;
      @(negedge clk);
      prog[0] = 32'hA5A5_0001;
      prog[1] = 32'h5A5A_0002;
      run_load(2, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
      run_load(DEPTH, 1'b0, 1'b0);
      run_load(3, 1'b1, 1'b0);
   endtask

   task automatic test_checksum();
`ifdef INST_LOADER_CHECKSUM_EN
      prog[0] = 32'h20010005;
      prog[1] = 32'h08000010;
      run_load(2, 1'b0, 1'b0);
      run_load(2, 1'b0, 1'b1);
      run_load(0, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      test_reset();
      test_two_word(1'b0);
      test_two_word(1'b1);
      test_overflow();
      test_reset_mid_word();
      test_back_to_back();
      test_checksum();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
